// File: rtl/serial_digit_comparator_if.sv
// Digit-serial operand stream and registered compare result for serial_digit_comparator.
// The producer drives the master side; the comparator sits on the slave side.
interface serial_digit_comparator_if #(
    parameter int DIGIT_W = 1
);
    logic               in_valid;
    logic               abort;
    logic               signed_mode;
    logic [DIGIT_W-1:0] a;
    logic [DIGIT_W-1:0] b;
    logic               busy;
    logic               out_valid;
    logic               a_less_b;
    logic               a_eq_b;
    logic               a_greater_b;

    modport master (
        output in_valid, abort, signed_mode, a, b,
        input  busy, out_valid, a_less_b, a_eq_b, a_greater_b
    );

    modport slave (
        input  in_valid, abort, signed_mode, a, b,
        output busy, out_valid, a_less_b, a_eq_b, a_greater_b
    );
endinterface

// File: rtl/serial_digit_comparator.sv
// Digit-serial magnitude comparator: folds WORD_LEN digits of A and B into one
// registered less/equal/greater result per word, with stalls and abort.
module serial_digit_comparator #(
    parameter int DIGIT_W   = 1,
    parameter int WORD_LEN  = 16,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    serial_digit_comparator_if.slave  bus
);
    localparam int CNT_W = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(WORD_LEN - 1);

    typedef enum logic [1:0] {
        CMP_EQ = 2'b00,
        CMP_LT = 2'b01,
        CMP_GT = 2'b10
    } cmp_t;

    logic [CNT_W-1:0]   digit_cnt;
    cmp_t               run_state;
    cmp_t               prev_state;
    cmp_t               digit_cmp;
    cmp_t               next_state;
    logic               mode_q;
    logic               first_digit;
    logic               last_digit;
    logic               sign_digit;
    logic               use_signed;
    logic [DIGIT_W-1:0] sign_mask;
    logic [DIGIT_W-1:0] a_adj;
    logic [DIGIT_W-1:0] b_adj;
    logic               out_valid_q;
    logic [2:0]         flags_q;

    // Flipping the sign bit of the sign-carrying digit turns a two's-complement
    // compare into an unsigned one, so the rest of the datapath stays unsigned.
    always_comb begin
        first_digit = (digit_cnt == '0);
        last_digit  = (digit_cnt == LAST_DIGIT);
        sign_digit  = MSB_FIRST ? first_digit : last_digit;
        use_signed  = first_digit ? bus.signed_mode : mode_q;

        sign_mask = '0;
        sign_mask[DIGIT_W-1] = use_signed && sign_digit;
        a_adj = bus.a ^ sign_mask;
        b_adj = bus.b ^ sign_mask;

        digit_cmp = CMP_EQ;
        if (a_adj < b_adj) begin
            digit_cmp = CMP_LT;
        end else if (a_adj > b_adj) begin
            digit_cmp = CMP_GT;
        end

        prev_state = first_digit ? CMP_EQ : run_state;
        next_state = prev_state;
        if (MSB_FIRST) begin
            if (prev_state == CMP_EQ) begin
                next_state = digit_cmp;
            end
        end else begin
            if (digit_cmp != CMP_EQ) begin
                next_state = digit_cmp;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_cnt   <= '0;
            run_state   <= CMP_EQ;
            mode_q      <= 1'b0;
            out_valid_q <= 1'b0;
            flags_q     <= 3'b010;
        end else begin
            out_valid_q <= 1'b0;
            if (bus.abort) begin
                digit_cnt <= '0;
                run_state <= CMP_EQ;
            end else if (bus.in_valid) begin
                if (first_digit) begin
                    mode_q <= bus.signed_mode;
                end
                if (last_digit) begin
                    digit_cnt   <= '0;
                    run_state   <= CMP_EQ;
                    out_valid_q <= 1'b1;
                    flags_q     <= {next_state == CMP_LT, next_state == CMP_EQ,
                                    next_state == CMP_GT};
                end else begin
                    digit_cnt <= digit_cnt + 1'b1;
                    run_state <= next_state;
                end
            end
        end
    end

    assign bus.busy        = (digit_cnt != '0);
    assign bus.out_valid   = out_valid_q;
    assign bus.a_less_b    = flags_q[2];
    assign bus.a_eq_b      = flags_q[1];
    assign bus.a_greater_b = flags_q[0];
endmodule

// File: tb/tb_serial_digit_comparator.sv
// Checks three comparator configurations (1x16 MSB-first, 4x4 MSB-first, 4x4 LSB-first)
// against whole-word integer compares of 16-bit operands.
module tb_serial_digit_comparator;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       drv_valid;
    logic       drv_abort;
    logic       drv_sgn;
    logic [3:0] drv_a;
    logic [3:0] drv_b;
    int         active;

    int         checks;
    int         errors;
    logic [2:0] held [3];
    int         cnt [3];
    int         dw_c [3]  = '{1, 4, 4};
    int         nd_c [3]  = '{16, 4, 4};
    bit         msb_c [3] = '{1'b1, 1'b1, 1'b0};

    serial_digit_comparator_if #(.DIGIT_W(1)) bus0 ();
    serial_digit_comparator_if #(.DIGIT_W(4)) bus1 ();
    serial_digit_comparator_if #(.DIGIT_W(4)) bus2 ();

    assign bus0.in_valid    = drv_valid && (active == 0);
    assign bus0.abort       = drv_abort && (active == 0);
    assign bus0.signed_mode = drv_sgn;
    assign bus0.a           = drv_a[0];
    assign bus0.b           = drv_b[0];
    assign bus1.in_valid    = drv_valid && (active == 1);
    assign bus1.abort       = drv_abort && (active == 1);
    assign bus1.signed_mode = drv_sgn;
    assign bus1.a           = drv_a;
    assign bus1.b           = drv_b;
    assign bus2.in_valid    = drv_valid && (active == 2);
    assign bus2.abort       = drv_abort && (active == 2);
    assign bus2.signed_mode = drv_sgn;
    assign bus2.a           = drv_a;
    assign bus2.b           = drv_b;

    serial_digit_comparator #(.DIGIT_W(1), .WORD_LEN(16), .MSB_FIRST(1'b1)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0));
    serial_digit_comparator #(.DIGIT_W(4), .WORD_LEN(4), .MSB_FIRST(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1));
    serial_digit_comparator #(.DIGIT_W(4), .WORD_LEN(4), .MSB_FIRST(1'b0)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2));

    logic       sel_ov;
    logic       sel_busy;
    logic [2:0] sel_flags;

    always_comb begin
        sel_ov    = bus0.out_valid;
        sel_busy  = bus0.busy;
        sel_flags = {bus0.a_less_b, bus0.a_eq_b, bus0.a_greater_b};
        if (active == 1) begin
            sel_ov    = bus1.out_valid;
            sel_busy  = bus1.busy;
            sel_flags = {bus1.a_less_b, bus1.a_eq_b, bus1.a_greater_b};
        end else if (active == 2) begin
            sel_ov    = bus2.out_valid;
            sel_busy  = bus2.busy;
            sel_flags = {bus2.a_less_b, bus2.a_eq_b, bus2.a_greater_b};
        end
    end

    // Reference result as {less, eq, greater} from whole-word integer values.
    function automatic logic [2:0] ref_cmp(logic [15:0] wa, logic [15:0] wb, bit sgn);
        int va;
        int vb;
        if (sgn) begin
            va = $signed(wa);
            vb = $signed(wb);
        end else begin
            va = int'(wa);
            vb = int'(wb);
        end
        if (va < vb) return 3'b100;
        if (va == vb) return 3'b010;
        return 3'b001;
    endfunction

    function automatic logic [3:0] get_digit(logic [15:0] w, int idx, int k);
        int pos;
        logic [15:0] t;
        pos = msb_c[k] ? (nd_c[k] - 1 - idx) : idx;
        t = w >> (pos * dw_c[k]);
        return (dw_c[k] == 1) ? {3'b000, t[0]} : t[3:0];
    endfunction

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s (dut %0d) got %0h expected %0h at %0t", tag, active, got, exp, $time);
        end
    endtask

    // One clock of stimulus, then compare out_valid, busy and flags against the model.
    task automatic cycle(input bit v, input bit ab, input int idx, input bit sgn,
                         input logic [15:0] wa, input logic [15:0] wb);
        bit last;
        @(negedge clk);
        drv_valid = v;
        drv_abort = ab;
        drv_sgn   = (idx == 0) ? sgn : 1'($urandom);
        if (v) begin
            drv_a = get_digit(wa, idx, active);
            drv_b = get_digit(wb, idx, active);
        end else begin
            drv_a = 4'($urandom);
            drv_b = 4'($urandom);
        end
        last = v && !ab && (idx == nd_c[active] - 1);
        @(posedge clk);
        #1;
        if (ab) cnt[active] = 0;
        else if (v) cnt[active] = (cnt[active] + 1) % nd_c[active];
        if (last) held[active] = ref_cmp(wa, wb, sgn);
        check_output("out_valid", 32'(sel_ov), 32'(last));
        check_output("busy", 32'(sel_busy), 32'(cnt[active] != 0));
        check_output("flags", 32'(sel_flags), 32'(held[active]));
    endtask

    task automatic apply_stimulus(input logic [15:0] wa, input logic [15:0] wb, input bit sgn,
                                  input int abort_at, input int max_stall);
        int n;
        for (int i = 0; i < nd_c[active]; i++) begin
            n = $urandom_range(max_stall, 0);
            repeat (n) cycle(1'b0, 1'b0, i, sgn, wa, wb);
            if (i == abort_at) begin
                cycle(1'b1, 1'b1, i, sgn, wa, wb);
                return;
            end
            cycle(1'b1, 1'b0, i, sgn, wa, wb);
        end
    endtask

    task automatic random_words(input int count, input int max_stall);
        logic [15:0] wa;
        logic [15:0] wb;
        for (int r = 0; r < count; r++) begin
            wa = 16'($urandom);
            wb = ($urandom_range(3, 0) == 0) ? wa : 16'($urandom);
            apply_stimulus(wa, wb, 1'($urandom), -1, max_stall);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        active    = 0;
        rst_n     = 1'b0;
        drv_valid = 1'b0;
        drv_abort = 1'b0;
        drv_sgn   = 1'b0;
        drv_a     = '0;
        drv_b     = '0;
        for (int k = 0; k < 3; k++) begin
            held[k] = 3'b010;
            cnt[k]  = 0;
        end

        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            active = k;
            #1;
            check_output("reset_out_valid", 32'(sel_ov), 32'd0);
            check_output("reset_busy", 32'(sel_busy), 32'd0);
            check_output("reset_flags", 32'(sel_flags), 32'(3'b010));
        end
        @(negedge clk);
        rst_n  = 1'b1;
        active = 0;

        // Bit-serial MSB-first: plain word, stalled word, idle abort, mid-word abort.
        apply_stimulus(16'b0110_0100_1000_0010, 16'b0110_0010_0110_0010, 1'b0, -1, 0);
        apply_stimulus(16'b0110_0100_1000_0010, 16'b0110_0010_0110_0010, 1'b0, -1, 3);
        cycle(1'b0, 1'b1, 0, 1'b0, 16'h0000, 16'h0000);
        apply_stimulus(16'h8000, 16'h0000, 1'b0, 5, 0);
        apply_stimulus(16'hA5A5, 16'hA5A5, 1'b1, -1, 0);
        random_words(5, 2);

        // Asynchronous reset in the middle of digit 7 after a "greater" result.
        apply_stimulus(16'h6482, 16'h6262, 1'b0, -1, 0);
        for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, i, 1'b0, 16'h1234, 16'h1200);
        @(negedge clk);
        drv_valid = 1'b1;
        drv_abort = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            held[k] = 3'b010;
            cnt[k]  = 0;
        end
        check_output("rst_mid_out_valid", 32'(sel_ov), 32'd0);
        check_output("rst_mid_busy", 32'(sel_busy), 32'd0);
        check_output("rst_mid_flags", 32'(sel_flags), 32'(3'b010));
        @(negedge clk);
        drv_valid = 1'b0;
        rst_n = 1'b1;
        apply_stimulus(16'h1234, 16'h1235, 1'b0, -1, 1);
        cycle(1'b0, 1'b0, 0, 1'b0, 16'h0000, 16'h0000);

        // Nibble-serial MSB-first, back-to-back words.
        active = 1;
        apply_stimulus(16'h8000, 16'h0001, 1'b0, -1, 0);
        apply_stimulus(16'h8000, 16'h0001, 1'b1, -1, 0);
        apply_stimulus(16'hBEEF, 16'hBEEF, 1'b1, -1, 0);
        random_words(8, 2);
        apply_stimulus(16'h7000, 16'h9000, 1'b1, 2, 0);
        random_words(4, 0);
        cycle(1'b0, 1'b0, 0, 1'b0, 16'h0000, 16'h0000);

        // Nibble-serial LSB-first: sign lives in the final digit.
        active = 2;
        apply_stimulus(16'h1234, 16'h2233, 1'b0, -1, 0);
        apply_stimulus(16'hF000, 16'h0FFF, 1'b1, -1, 0);
        apply_stimulus(16'hF000, 16'h0FFF, 1'b0, -1, 0);
        random_words(8, 2);
        apply_stimulus(16'h0F0F, 16'h0F0E, 1'b0, 3, 0);
        random_words(4, 0);
        cycle(1'b0, 1'b0, 0, 1'b0, 16'h0000, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_digit_comparator.md
Name: serial_digit_comparator

Overview:
- Parametrised digit-serial magnitude comparator. Accepts two operands DIGIT_W bits per cycle over WORD_LEN digits.
- Digit order (MSB-first or LSB-first) is fixed by parameter. Signed or unsigned comparison is chosen per word at run time.
- Emits one registered less/equal/greater result per word.
- Sits downstream of serial links and shift-register front-ends that deliver operands digit by digit with gaps allowed.

Parameters:
- DIGIT_W, 1: bits of each operand per accepted digit (>=1).
- WORD_LEN, 16: digits per word (>=1); word width = DIGIT_W*WORD_LEN.
- MSB_FIRST, 1: 1 = most significant digit first, 0 = least significant digit first.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  a/b carry a valid digit this cycle; low = stall.
- abort  in  1  synchronous discard of the word in progress.
- signed_mode  in  1  two's-complement compare for this word; sampled only on digit 0.
- a  in  DIGIT_W  digit of operand A.
- b  in  DIGIT_W  digit of operand B.
- busy  out  1  word partially received (digit counter != 0).
- out_valid  out  1  one-cycle pulse: result flags updated.
- a_less_b  out  1  registered result: A < B.
- a_eq_b  out  1  registered result: A == B.
- a_greater_b  out  1  registered result: A > B.

Behaviour:
- Reset (rst_n low, asynchronous): digit counter 0, running state "equal", latched mode unsigned. Outputs: out_valid 0, busy 0, a_eq_b 1, a_less_b 0, a_greater_b 0.
- Result flags are one-hot at all times after reset.
- Digit counter runs 0..WORD_LEN-1 and advances only on accepted digits (in_valid=1, abort=0).
  - Wraps to 0 after the last digit, so words run back-to-back with no idle cycle.
  - Counter width is max(1, $clog2(WORD_LEN)).
- Running state is two-bit (lt/gt; neither = equal). It resets to equal whenever digit 0 is accepted, before that digit is applied.
- Sign handling: when the latched mode is signed, the top bit of the sign-carrying digit of both a and b is inverted before comparing. The sign-carrying digit is digit 0 if MSB_FIRST, otherwise digit WORD_LEN-1. Everything else is an unsigned digit compare.
- Mode latch: signed_mode is captured when digit 0 is accepted and used for the whole word. For MSB_FIRST the combinational path uses signed_mode directly on digit 0.
- MSB_FIRST=1 update: once the running state is lt or gt it is sticky. While equal, the digit compare (a<b, a>b) sets it.
- MSB_FIRST=0 update: a digit with a != b overwrites the running state with that digit's compare. Equal digits keep the previous state.
- Result: on acceptance of digit WORD_LEN-1, the next cycle shows out_valid=1 and the flags loaded with the final state including that digit (latency 1 cycle after last digit).
  - Flags then hold until the next out_valid; out_valid is low otherwise.
- WORD_LEN=1: every accepted digit is both first and last; out_valid follows each accepted digit by one cycle.
- Stall: in_valid low freezes counter, running state and latched mode. Gaps of any length are allowed mid-word.
- Abort: counter and running state are cleared to the idle/equal condition. No out_valid is produced, and previously reported flags are unchanged.
  - abort wins over in_valid in the same cycle; that digit is dropped.
  - Abort while idle is a no-op.
- Reset mid-word: asynchronous clear as above. The partial word is lost and no out_valid is produced.
- busy = (counter != 0); it drops in the cycle after the last digit is accepted.

Test Plan:
- Defaults (DIGIT_W=1, WORD_LEN=16, MSB_FIRST=1), unsigned, feed a=16'b0110_0100_1000_0010, b=16'b0110_0010_0110_0010 MSB first, one bit per cycle -> single out_valid pulse 1 cycle after bit 15, flags less=0 eq=0 greater=1; busy high from bit 1 through last accept.
- DIGIT_W=4, WORD_LEN=4, MSB_FIRST=1, a=16'h8000, b=16'h0001: unsigned -> greater=1; repeat back-to-back with signed_mode=1 -> less=1; then a=b=16'hBEEF signed -> eq=1. Three out_valid pulses exactly 4 cycles apart.
- DIGIT_W=4, WORD_LEN=4, MSB_FIRST=0, a=16'h1234, b=16'h2233 LSB digit first -> less=1 (decided by digit 3). Then a=16'hF000, b=16'h0FFF signed -> less=1, unsigned -> greater=1.
- Stall: defaults, same stimulus as scenario 1 with in_valid low for 3 cycles after bits 4 and 11 -> identical flags, out_valid only after the 16th accepted bit.
- Abort: start a word with a>b in the first digit, assert abort at digit 5 together with in_valid -> no out_valid, flags keep prior values, busy=0 next cycle. A following full word a=b -> eq=1.
- Reset: drop rst_n asynchronously mid-cycle during digit 7 -> immediately out_valid=0, busy=0, eq=1, less=0, greater=0. The next full word compares correctly from digit 0.
